// File: rtl/aging_sensor_pkg.sv
// Shared types, limits and width helpers for the aging-sensor blocks.
package aging_sensor_pkg;

    // Qualification FSM states; prefixed so they never collide with the
    // CONFIRM / HOLDOFF parameters of the blocks that import this package.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Legal parameter ranges.
    localparam int CONFIRM_MIN = 1;
    localparam int CONFIRM_MAX = 15;
    localparam int HOLDOFF_MIN = 0;
    localparam int HOLDOFF_MAX = 255;

    // Bits needed to hold values 0..n, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Widest counters any legal configuration can need.
    localparam int CONFIRM_W_MAX = cnt_width(CONFIRM_MAX);
    localparam int HOLD_W_MAX    = cnt_width(HOLDOFF_MAX);

endpackage

// File: rtl/aging_holdoff_timer.sv
// Loadable down-counter: load sets the count, en decrements toward zero,
// abort clears it. expire flags the decrement that takes the count 1 -> 0.
module aging_holdoff_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         abort,
    output logic         active,
    output logic         expire
);

    logic [W-1:0] count;

    // Count register: abort beats load, load beats decrement; stops at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (abort) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // Status decode for the owner of the timer.
    always_comb begin
        active = (count != '0);
        expire = en && (count == W'(1));
    end

endmodule

// File: rtl/aging_warning_gen.sv
// Aging warning generator: qualifies main/shadow mismatches over CONFIRM
// consecutive cycles, emits a one-cycle warning pulse, then holds off.
//
// Handshake: there is no backpressure. warning_signal is a registered
// single-cycle strobe; the downstream counter must accept it every cycle.
module aging_warning_gen
    import aging_sensor_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CONFIRM = 2,
    parameter int HOLDOFF = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] main_q,
    input  logic [WIDTH-1:0] shadow_q,
    input  logic [WIDTH-1:0] path_mask,
    input  logic             clear_status,
    output logic             warning_signal,
    output logic [WIDTH-1:0] warning_status,
    output logic             holdoff_active
);

    localparam int CNT_W  = cnt_width(CONFIRM);
    localparam int HOLD_W = cnt_width(HOLDOFF);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] cap_next;
    logic [WIDTH-1:0] cap_final;
    logic [WIDTH-1:0] mm_vec;
    logic [WIDTH-1:0] status_next;
    logic             mm;
    logic             fire;
    logic             tmr_load;
    logic             tmr_abort;
    logic             tmr_en;
    logic             tmr_active;
    logic             tmr_expire;

    // Per-cycle mismatch terms; cap_final is what a fire on this edge records.
    always_comb begin
        mm_vec    = (main_q ^ shadow_q) & path_mask;
        mm        = enable && (|mm_vec);
        cap_final = cap | mm_vec;
        tmr_en    = (state == ST_HOLDOFF);
    end

    aging_holdoff_timer #(
        .W (HOLD_W)
    ) u_holdoff_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (HOLD_W'(HOLDOFF)),
        .en       (tmr_en),
        .abort    (tmr_abort),
        .active   (tmr_active),
        .expire   (tmr_expire)
    );

    // Next-state logic; fire is an edge action that overrides the state move.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cap_next   = cap;
        fire       = 1'b0;
        tmr_load   = 1'b0;
        tmr_abort  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mm) begin
                    if (CONFIRM == 1) begin
                        fire = 1'b1;
                    end else begin
                        state_next = ST_CONFIRM;
                        cnt_next   = CNT_W'(1);
                        cap_next   = mm_vec;
                    end
                end
            end
            ST_CONFIRM: begin
                if (mm) begin
                    if ((cnt + CNT_W'(1)) == CNT_W'(CONFIRM)) begin
                        fire = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                        cap_next = cap_final;
                    end
                end else begin
                    // Any gap (or enable low) restarts qualification.
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    cap_next   = '0;
                end
            end
            ST_HOLDOFF: begin
                // Mismatches are ignored here; leave on expiry or enable low.
                if (!enable || tmr_expire || !tmr_active) begin
                    state_next = ST_IDLE;
                    tmr_abort  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                cap_next   = '0;
                tmr_abort  = 1'b1;
            end
        endcase
        if (fire) begin
            cnt_next = '0;
            cap_next = '0;
            if (HOLDOFF == 0) begin
                state_next = ST_IDLE;
            end else begin
                state_next = ST_HOLDOFF;
                tmr_load   = 1'b1;
            end
        end
    end

    // Sticky status: new bits from a fire survive a coincident clear.
    always_comb begin
        status_next = warning_status;
        if (fire) begin
            status_next = (clear_status ? '0 : warning_status) | cap_final;
        end else if (clear_status) begin
            status_next = '0;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            cap            <= '0;
            warning_signal <= 1'b0;
            warning_status <= '0;
            holdoff_active <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            cap            <= cap_next;
            warning_signal <= fire;
            warning_status <= status_next;
            holdoff_active <= (state_next == ST_HOLDOFF);
        end
    end

endmodule
